// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instruction and bypassed operands,
// inserts load-use bubbles, honours EX back-pressure and branch flush, counts bubbles/flushes.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int RS_WIDTH   = 5,
    parameter int PC_WIDTH   = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [PC_WIDTH-1:0]   id_pc,
    input  logic [RS_WIDTH-1:0]   id_rs1,
    input  logic [RS_WIDTH-1:0]   id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RS_WIDTH-1:0]   id_rd,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic                  id_memread,
    input  logic                  id_regwrite,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic                  wb_regwrite,
    input  logic [RS_WIDTH-1:0]   wb_rd,
    input  logic [XLEN-1:0]       wb_wdata,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [PC_WIDTH-1:0]   ex_pc,
    output logic [RS_WIDTH-1:0]   ex_rs1,
    output logic [RS_WIDTH-1:0]   ex_rs2,
    output logic [RS_WIDTH-1:0]   ex_rd,
    output logic [XLEN-1:0]       ex_op1,
    output logic [XLEN-1:0]       ex_op2,
    output logic [XLEN-1:0]       ex_imm,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic                  ex_memread,
    output logic                  ex_regwrite,
    output logic [CNT_WIDTH-1:0]  bubble_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            load_use;

    // The register file commits WB only at the next edge, so a same-cycle write must be bypassed here.
    always_comb begin
        op1 = rf_rdata1;
        if (id_rs1 == '0)
            op1 = '0;
        else if (wb_regwrite && (wb_rd == id_rs1))
            op1 = wb_wdata;

        op2 = rf_rdata2;
        if (id_rs2 == '0)
            op2 = '0;
        else if (wb_regwrite && (wb_rd == id_rs2))
            op2 = wb_wdata;
    end

    assign load_use = ex_valid && ex_memread && (ex_rd != '0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    assign id_stall = !rst && !flush && (!ex_ready || load_use);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
            bubble_cnt  <= '0;
            flush_cnt   <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
            if (flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end else if (!ex_ready) begin
            // EX is holding its instruction: everything, counters included, stays put.
        end else if (load_use) begin
            ex_valid    <= 1'b0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
            if (bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_op1      <= op1;
            ex_op2      <= op2;
            ex_imm      <= id_imm;
            ex_ctrl     <= id_ctrl;
            ex_memread  <= id_memread && id_valid;
            ex_regwrite <= id_regwrite && id_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against
// an instruction-level reference model; a 4-bit-counter instance exercises saturation.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int RSW   = 5;
    localparam int PCW   = 32;
    localparam int CW    = 16;
    localparam int CNTW  = 16;
    localparam int SCNTW = 4;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic [PCW-1:0]  id_pc;
    logic [RSW-1:0]  id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [XLEN-1:0] id_imm;
    logic [CW-1:0]   id_ctrl;
    logic            id_memread, id_regwrite;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            wb_regwrite;
    logic [RSW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_wdata;
    logic            ex_ready, flush;

    logic            id_stall, ex_valid, ex_memread, ex_regwrite;
    logic [PCW-1:0]  ex_pc;
    logic [RSW-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0] ex_op1, ex_op2, ex_imm;
    logic [CW-1:0]   ex_ctrl;
    logic [CNTW-1:0] bubble_cnt, flush_cnt;

    logic             s_id_stall, s_ex_valid, s_ex_memread, s_ex_regwrite;
    logic [PCW-1:0]   s_ex_pc;
    logic [RSW-1:0]   s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [XLEN-1:0]  s_ex_op1, s_ex_op2, s_ex_imm;
    logic [CW-1:0]    s_ex_ctrl;
    logic [SCNTW-1:0] s_bubble_cnt, s_flush_cnt;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_memread(id_memread),
        .id_regwrite(id_regwrite), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.CNT_WIDTH(SCNTW)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_memread(id_memread),
        .id_regwrite(id_regwrite), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .ex_ready(ex_ready), .flush(flush), .id_stall(s_id_stall), .ex_valid(s_ex_valid),
        .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
        .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
        .ex_memread(s_ex_memread), .ex_regwrite(s_ex_regwrite),
        .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction sitting in EX plus true event counts (saturated only when compared).
    typedef struct packed {
        logic            valid;
        logic [PCW-1:0]  pc;
        logic [RSW-1:0]  rs1, rs2, rd;
        logic [XLEN-1:0] op1, op2, imm;
        logic [CW-1:0]   ctrl;
        logic            memread, regwrite;
    } slot_t;

    slot_t       m;
    int unsigned m_bubbles;
    int unsigned m_flushes;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [XLEN-1:0] readReg(input logic [RSW-1:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 0) return '0;
        if (wb_regwrite && wb_rd == rs) return wb_wdata;
        return rf;
    endfunction

    task automatic compareAll();
        checkOutput("ex_valid", 32'(ex_valid), 32'(m.valid));
        checkOutput("ex_memread", 32'(ex_memread), 32'(m.memread));
        checkOutput("ex_regwrite", 32'(ex_regwrite), 32'(m.regwrite));
        checkOutput("bubble_cnt", 32'(bubble_cnt), sat(m_bubbles, 32'hFFFF));
        checkOutput("flush_cnt", 32'(flush_cnt), sat(m_flushes, 32'hFFFF));
        checkOutput("sat_bubble_cnt", 32'(s_bubble_cnt), sat(m_bubbles, 32'hF));
        checkOutput("sat_flush_cnt", 32'(s_flush_cnt), sat(m_flushes, 32'hF));
        if (m.valid) begin
            checkOutput("ex_pc", ex_pc, m.pc);
            checkOutput("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
            checkOutput("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
            checkOutput("ex_rd", 32'(ex_rd), 32'(m.rd));
            checkOutput("ex_op1", ex_op1, m.op1);
            checkOutput("ex_op2", ex_op2, m.op2);
            checkOutput("ex_imm", ex_imm, m.imm);
            checkOutput("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
        end
    endtask

    // One clock: check the combinational stall, let the edge happen, advance the model, compare.
    task automatic stepCycle();
        logic hazard, exp_stall;
        #1;
        hazard = m.valid && m.memread && (m.rd != 0) && id_valid &&
                 ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
        exp_stall = !rst && !flush && (!ex_ready || hazard);
        checkOutput("id_stall", 32'(id_stall), 32'(exp_stall));
        @(posedge clk);
        if (rst) begin
            m = '0;
            m_bubbles = 0;
            m_flushes = 0;
        end else if (flush) begin
            m.valid = 1'b0; m.memread = 1'b0; m.regwrite = 1'b0;
            m_flushes++;
        end else if (!ex_ready) begin
            // EX holds; nothing moves
        end else if (hazard) begin
            m.valid = 1'b0; m.memread = 1'b0; m.regwrite = 1'b0;
            m_bubbles++;
        end else begin
            m.valid    = id_valid;
            m.pc       = id_pc;
            m.rs1      = id_rs1;
            m.rs2      = id_rs2;
            m.rd       = id_rd;
            m.op1      = readReg(id_rs1, rf_rdata1);
            m.op2      = readReg(id_rs2, rf_rdata2);
            m.imm      = id_imm;
            m.ctrl     = id_ctrl;
            m.memread  = id_memread && id_valid;
            m.regwrite = id_regwrite && id_valid;
        end
        #1;
        compareAll();
    endtask

    task automatic applyStimulus(input logic v, input logic [RSW-1:0] rs1, input logic [RSW-1:0] rs2,
                                 input logic [RSW-1:0] rd, input logic u1, input logic u2,
                                 input logic mr, input logic rw);
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_memread = mr; id_regwrite = rw;
        id_pc = $urandom; id_imm = $urandom; id_ctrl = CW'($urandom);
        rf_rdata1 = $urandom; rf_rdata2 = $urandom;
        wb_regwrite = 1'b0; wb_rd = '0; wb_wdata = $urandom;
    endtask

    logic [PCW-1:0] held_pc;

    initial begin
        m = '0; m_bubbles = 0; m_flushes = 0;
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset with a valid instruction and EX not ready: stall must still read 0.
        rst = 1'b1; ex_ready = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("reset_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset_bubbles", 32'(bubble_cnt), 32'd0);
        checkOutput("reset_flushes", 32'(flush_cnt), 32'd0);
        checkOutput("reset_stall", 32'(id_stall), 32'd0);

        // Same-cycle WB bypass, and x0 always reads zero.
        applyStimulus(1'b1, 5'd5, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        rf_rdata1 = 32'h11; wb_regwrite = 1'b1; wb_rd = 5'd5; wb_wdata = 32'hDEADBEEF;
        stepCycle();
        checkOutput("bypass_op1", ex_op1, 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        rf_rdata1 = 32'h11; wb_regwrite = 1'b1; wb_rd = 5'd0; wb_wdata = 32'hDEADBEEF;
        stepCycle();
        checkOutput("bypass_x0", ex_op1, 32'd0);

        // lw x7 then add x8,x7,x1: one bubble, then the add is captured.
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        held_pc = id_pc;
        #1;
        checkOutput("lu_stall", 32'(id_stall), 32'd1);
        stepCycle();
        checkOutput("lu_bubble", 32'(ex_valid), 32'd0);
        stepCycle();
        checkOutput("lu_capture", 32'(ex_valid), 32'd1);
        checkOutput("lu_capture_pc", ex_pc, held_pc);
        checkOutput("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Same add but rs1 not actually read: no stall.
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("nouse_stall", 32'(id_stall), 32'd0);
        stepCycle();
        checkOutput("nouse_capture", 32'(ex_valid), 32'd1);

        // Back-pressure for 3 cycles.
        applyStimulus(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        held_pc = id_pc;
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd2, 5'd6, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
            ex_ready = 1'b0;
            stepCycle();
            checkOutput("bp_pc_held", ex_pc, held_pc);
        end
        checkOutput("bp_bubbles", 32'(bubble_cnt), 32'd1);

        // Flush coinciding with a load-use hazard: flush wins.
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        flush = 1'b1;
        #1;
        checkOutput("fl_stall", 32'(id_stall), 32'd0);
        stepCycle();
        checkOutput("fl_valid", 32'(ex_valid), 32'd0);
        checkOutput("fl_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("fl_bubble_cnt", 32'(bubble_cnt), 32'd1);

        // Reset in the middle of a pending load-use hazard.
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        stepCycle();
        checkOutput("rst_mid_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst_mid_bubbles", 32'(bubble_cnt), 32'd0);

        // A load depending on its own rd alternates capture and bubble: saturates the 4-bit counter.
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) stepCycle();
        checkOutput("sat_bubble", 32'(s_bubble_cnt), 32'hF);
        checkOutput("sat_bubble_main", 32'(bubble_cnt), 32'd20);
        for (int i = 0; i < 20; i++) begin
            flush = 1'b1;
            stepCycle();
        end
        checkOutput("sat_flush", 32'(s_flush_cnt), 32'hF);

        // Randomized traffic with small register indices to provoke hazards and bypasses.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(99, 0) < 80,
                          RSW'($urandom_range(7, 0)), RSW'($urandom_range(7, 0)),
                          RSW'($urandom_range(7, 0)),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            wb_regwrite = 1'($urandom);
            wb_rd       = RSW'($urandom_range(7, 0));
            ex_ready    = $urandom_range(99, 0) < 85;
            flush       = $urandom_range(99, 0) < 10;
            rst         = $urandom_range(199, 0) < 3;
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
